cell_mem_arbiter: RTL and testbench
===================================

Name: cell_mem_arbiter

Overview:
- Owns the single-port synchronous cell-board RAM and shares it between three requesters:
  - the display path, which reads the cell under the VGA scan position;
  - the edit path, which toggles the cell under the cursor with a read-modify-write;
  - the evolve engine, which does generation reads and writes.
- Sits between the display controller / evolve engine and the board RAM.
- Display reads have absolute priority during active display. Edit and evolve share the remaining cycles with alternating priority.

Parameters:
- ADDR_W, 8, width of each cell coordinate (matches `ADDR_WIDTH).
- RD_LAT, 1, RAM read latency in cycles. Fixed at 1; any other value is unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  1  `MODE_EDIT pauses evolve grants
- disp_active  in  1  display owns the port this cycle (in_disp_area)
- cell_x  in  ADDR_W  display read column
- cell_y  in  ADDR_W  display read row
- cell_state  out  1  display read data
- edit_req  in  1  level; toggle request, held until edit_done
- cur_x  in  ADDR_W  edit column, stable while edit_req is high
- cur_y  in  ADDR_W  edit row, stable while edit_req is high
- edit_done  out  1  one-cycle pulse when the toggle write is issued
- evo_req  in  1  level; held with addr/we/wdata until evo_gnt
- evo_we  in  1  1 = write, 0 = read
- evo_x  in  ADDR_W  evolve column
- evo_y  in  ADDR_W  evolve row
- evo_wdata  in  1  evolve write data
- evo_gnt  out  1  one-cycle pulse; the access was issued this cycle
- evo_rvalid  out  1  pulse one cycle after a read grant
- evo_rdata  out  1  valid while evo_rvalid is high
- mem_x  out  ADDR_W  RAM column address
- mem_y  out  ADDR_W  RAM row address
- mem_we  out  1  RAM write enable
- mem_wdata  out  1  RAM write data
- mem_rdata  in  1  RAM read data, valid 1 cycle after the address

Behaviour:

Reset (asynchronous):
- state = IDLE.
- cell_state, edit_done, evo_gnt, evo_rvalid, evo_rdata, mem_we, mem_wdata = 0.
- prio_edit = 1.
- Latched toggle data = 0.

Port mux (combinational):
- disp_active = 1: mem_x/mem_y = cell_x/cell_y, mem_we = 0, regardless of state.
- Otherwise the address, we and wdata come from the state's owner. In IDLE with no grant, the address is 0 and mem_we = 0.

Read-data steering:
- An owner register records who issued the previous cycle's access: DISP, EDIT, EVO or NONE.
- Owner DISP: cell_state <= mem_rdata. Otherwise cell_state holds its value. Display latency is 1 cycle from cell_x/cell_y to cell_state.
- Owner EVO-read: evo_rdata <= mem_rdata and evo_rvalid = 1 for that one cycle.

FSM states: IDLE, EDIT_RD, EDIT_WAIT, EDIT_WR.

IDLE, when disp_active = 0:
- Candidates:
  - edit_req = 1;
  - evo_req = 1 and mode != `MODE_EDIT.
- Only edit pending: go to EDIT_RD; the read of cur_x/cur_y is issued this cycle.
- Only evolve pending: issue the access, pulse evo_gnt, stay in IDLE.
- Both pending: prio_edit selects the winner. prio_edit toggles after every edit completion or evo grant, so winners strictly alternate.
- When disp_active = 1, nothing is granted.

EDIT_RD: go to EDIT_WAIT. Owner EDIT captures mem_rdata into the toggle latch.

EDIT_WAIT:
- disp_active = 0: write ~latch to cur_x/cur_y (mem_we = 1), pulse edit_done, go to EDIT_WR.
- disp_active = 1: stay; the latch is preserved.

EDIT_WR: go to IDLE. edit_done has already pulsed.

RMW atomicity:
- No evolve access is granted between EDIT_RD and the edit write.
- Display may interleave; it never writes, so the toggle stays correct.

Preemption:
- disp_active rising in IDLE while a request is pending: no grant, requests wait.
- disp_active rising in the EDIT_RD cycle: the read address goes to display, so the edit read is lost. The FSM returns to EDIT_RD, not EDIT_WAIT, and retries once disp_active falls.

Mode:
- Entering `MODE_EDIT while evo_req is pending: no further evo_gnt.
- An already-issued read still produces evo_rvalid.

Request hygiene:
- edit_req is sampled again only in IDLE. The requester must drop it the cycle after edit_done, otherwise a second toggle occurs.
- Coordinates wrap naturally at 2^ADDR_W; the arbiter does no range checks.

Reset mid-operation: an in-flight RMW is abandoned and no write is issued.

Test Plan:
1. disp_active = 1, cell_x = 3, cell_y = 5, RAM(3,5) = 1 -> mem_x/mem_y = 3/5 the same cycle, mem_we = 0; cell_state = 1 one cycle later; evo_req = 1 held gets no evo_gnt.
2. disp_active = 0, edit_req at (7,2) with RAM = 0 -> read cycle, then a write of 1 to (7,2) with a single edit_done pulse 2 cycles after the request; RAM(7,2) = 1.
3. Edit RMW with disp_active asserted for 4 cycles in EDIT_WAIT -> no write during those cycles; the write of the inverted value is issued the first cycle disp_active = 0.
4. mode = run, edit_req and evo_req held continuously -> grants alternate edit, evo, edit, evo; no evo_gnt between an edit read and its write.
5. mode = `MODE_EDIT, evo read req at (1,1) -> no evo_gnt for 20 cycles; switch mode to run -> evo_gnt, then evo_rvalid the next cycle with evo_rdata = RAM(1,1).
6. Assert rst during EDIT_WAIT -> all outputs are 0 immediately; no write to the edit cell occurs; after release the state is IDLE and prio_edit = 1.

Source files
------------

// File: rtl/cell_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cell_mem_arbiter
// Description : Shares the single-port cell-board RAM between the display
//               scan, the cursor toggle (read-modify-write) and the evolve engine.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

module cell_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] cell_x,
  input  logic [ADDR_W-1:0] cell_y,
  output logic              cell_state,
  input  logic              edit_req,
  input  logic [ADDR_W-1:0] cur_x,
  input  logic [ADDR_W-1:0] cur_y,
  output logic              edit_done,
  input  logic              evo_req,
  input  logic              evo_we,
  input  logic [ADDR_W-1:0] evo_x,
  input  logic [ADDR_W-1:0] evo_y,
  input  logic              evo_wdata,
  output logic              evo_gnt,
  output logic              evo_rvalid,
  output logic              evo_rdata,
  output logic [ADDR_W-1:0] mem_x,
  output logic [ADDR_W-1:0] mem_y,
  output logic              mem_we,
  output logic              mem_wdata,
  input  logic              mem_rdata
);

  generate
    if (RD_LAT != 1) begin : g_rd_lat_unsupported
      $error("cell_mem_arbiter supports RD_LAT == 1 only");
    end
  endgenerate

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_EDIT_RD   = 2'd1;
  localparam logic [1:0] c_EDIT_WAIT = 2'd2;
  localparam logic [1:0] c_EDIT_WR   = 2'd3;

  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_DISP = 2'd1;
  localparam logic [1:0] c_OWN_EDIT = 2'd2;
  localparam logic [1:0] c_OWN_EVO  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_owner;
  logic [1:0]        w_owner_nxt;
  logic              r_prio_edit;
  logic              r_toggle;
  logic              r_cell_state;
  logic              r_evo_rdata;
  logic              w_evo_cand;
  logic              w_grant_edit;
  logic              w_grant_evo;
  logic              w_capture;
  logic              w_edit_wr;
  logic [ADDR_W-1:0] w_x;
  logic [ADDR_W-1:0] w_y;
  logic              w_we;
  logic              w_wdata;

  // Arbitration only happens in IDLE; display ownership blocks every grant.
  always_comb begin
    w_evo_cand   = evo_req && (mode != `MODE_EDIT);
    w_grant_edit = 1'b0;
    w_grant_evo  = 1'b0;
    if (r_state == c_IDLE && !disp_active) begin
      w_grant_edit = edit_req && (!w_evo_cand || r_prio_edit);
      w_grant_evo  = w_evo_cand && (!edit_req || !r_prio_edit);
    end
  end

  always_comb begin
    w_x         = '0;
    w_y         = '0;
    w_we        = 1'b0;
    w_wdata     = 1'b0;
    w_owner_nxt = c_OWN_NONE;
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_edit_wr   = 1'b0;
    if (disp_active) begin
      w_x         = cell_x;
      w_y         = cell_y;
      w_owner_nxt = c_OWN_DISP;
    end
    case (r_state)
      c_IDLE: begin
        if (w_grant_edit) begin
          w_x         = cur_x;
          w_y         = cur_y;
          w_owner_nxt = c_OWN_EDIT;
          w_state_nxt = c_EDIT_RD;
        end else if (w_grant_evo) begin
          w_x         = evo_x;
          w_y         = evo_y;
          w_we        = evo_we;
          w_wdata     = evo_wdata;
          w_owner_nxt = evo_we ? c_OWN_NONE : c_OWN_EVO;
        end
      end
      // A read stolen by the display is reissued here before moving on.
      c_EDIT_RD: begin
        if (!disp_active) begin
          if (r_owner == c_OWN_EDIT) begin
            w_capture   = 1'b1;
            w_state_nxt = c_EDIT_WAIT;
          end else begin
            w_x         = cur_x;
            w_y         = cur_y;
            w_owner_nxt = c_OWN_EDIT;
          end
        end
      end
      c_EDIT_WAIT: begin
        if (!disp_active) begin
          w_x         = cur_x;
          w_y         = cur_y;
          w_we        = 1'b1;
          w_wdata     = ~r_toggle;
          w_edit_wr   = 1'b1;
          w_state_nxt = c_EDIT_WR;
        end
      end
      c_EDIT_WR: w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_owner      <= c_OWN_NONE;
      r_prio_edit  <= 1'b1;
      r_toggle     <= 1'b0;
      r_cell_state <= 1'b0;
      r_evo_rdata  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (w_capture)
        r_toggle <= mem_rdata;
      if (w_edit_wr || w_grant_evo)
        r_prio_edit <= ~r_prio_edit;
      if (r_owner == c_OWN_DISP)
        r_cell_state <= mem_rdata;
      if (r_owner == c_OWN_EVO)
        r_evo_rdata <= mem_rdata;
    end
  end

  // Read data is forwarded in the return cycle, then held in the registers.
  assign cell_state = !rst && ((r_owner == c_OWN_DISP) ? mem_rdata : r_cell_state);
  assign evo_rvalid = !rst && (r_owner == c_OWN_EVO);
  assign evo_rdata  = !rst && ((r_owner == c_OWN_EVO) ? mem_rdata : r_evo_rdata);
  assign edit_done  = !rst && w_edit_wr;
  assign evo_gnt    = !rst && w_grant_evo;
  assign mem_x      = rst ? '0 : w_x;
  assign mem_y      = rst ? '0 : w_y;
  assign mem_we     = !rst && w_we;
  assign mem_wdata  = !rst && w_wdata;

endmodule

`default_nettype wire

// File: tb/tb_cell_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_mem_arbiter
// Description : Directed self-checking bench for cell_mem_arbiter with a
//               behavioural 256x256 single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_cell_mem_arbiter;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic              disp_active;
  logic [ADDR_W-1:0] cell_x, cell_y;
  logic              cell_state;
  logic              edit_req;
  logic [ADDR_W-1:0] cur_x, cur_y;
  logic              edit_done;
  logic              evo_req, evo_we, evo_wdata;
  logic [ADDR_W-1:0] evo_x, evo_y;
  logic              evo_gnt, evo_rvalid, evo_rdata;
  logic [ADDR_W-1:0] mem_x, mem_y;
  logic              mem_we, mem_wdata;
  logic              mem_rdata;

  logic ram [0:255][0:255];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [9:0] exp_done, exp_gnt, exp_we, exp_wd;

  always #5 clk = ~clk;

  cell_mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .disp_active(disp_active),
    .cell_x(cell_x), .cell_y(cell_y), .cell_state(cell_state),
    .edit_req(edit_req), .cur_x(cur_x), .cur_y(cur_y), .edit_done(edit_done),
    .evo_req(evo_req), .evo_we(evo_we), .evo_x(evo_x), .evo_y(evo_y),
    .evo_wdata(evo_wdata), .evo_gnt(evo_gnt), .evo_rvalid(evo_rvalid),
    .evo_rdata(evo_rdata), .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: one process owns the array; synchronous read-before-write.
  initial begin
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        ram[i][j] = 1'b0;
    ram[3][5] = 1'b1;
    ram[4][4] = 1'b1;
    ram[1][1] = 1'b1;
    mem_rdata = 1'b0;
    forever begin
      @(posedge clk);
      mem_rdata <= ram[mem_x][mem_y];
      if (mem_we)
        ram[mem_x][mem_y] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; disp_active = 1'b0; cell_x = '0; cell_y = '0;
    edit_req = 1'b0; cur_x = '0; cur_y = '0;
    evo_req = 1'b0; evo_we = 1'b0; evo_x = '0; evo_y = '0; evo_wdata = 1'b0;

    // Reset state
    step(); step(); #1;
    check("rst cell_state", cell_state, 0);
    check("rst edit_done", edit_done, 0);
    check("rst evo_gnt", evo_gnt, 0);
    check("rst evo_rvalid", evo_rvalid, 0);
    check("rst evo_rdata", evo_rdata, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_wdata", mem_wdata, 0);
    step(); rst = 1'b0;

    // Display read with a competing evolve request
    step(); disp_active = 1'b1; cell_x = 3; cell_y = 5;
    evo_req = 1'b1; evo_we = 1'b0; evo_x = 9; evo_y = 9; #1;
    check("disp mem_x", mem_x, 3);
    check("disp mem_y", mem_y, 5);
    check("disp mem_we", mem_we, 0);
    check("disp evo_gnt", evo_gnt, 0);
    step(); #1;
    check("disp cell_state", cell_state, 1);
    check("disp evo_gnt 2", evo_gnt, 0);
    step(); disp_active = 1'b0; evo_req = 1'b0; #1;
    step(); #1;
    check("disp cell_state hold", cell_state, 1);

    // Plain edit toggle at (7,2), RAM = 0
    step(); edit_req = 1'b1; cur_x = 7; cur_y = 2; #1;
    check("edit rd mem_x", mem_x, 7);
    check("edit rd mem_y", mem_y, 2);
    check("edit rd mem_we", mem_we, 0);
    check("edit rd done", edit_done, 0);
    step(); #1;
    check("edit cap done", edit_done, 0);
    check("edit cap mem_we", mem_we, 0);
    step(); #1;
    check("edit wr done", edit_done, 1);
    check("edit wr mem_we", mem_we, 1);
    check("edit wr wdata", mem_wdata, 1);
    check("edit wr mem_x", mem_x, 7);
    check("edit wr mem_y", mem_y, 2);
    step(); edit_req = 1'b0; #1;
    check("edit after done", edit_done, 0);
    check("edit after we", mem_we, 0);
    check("edit ram(7,2)", ram[7][2], 1);

    // Edit at (4,4), RAM = 1, display holds the port 4 cycles in EDIT_WAIT
    step(); edit_req = 1'b1; cur_x = 4; cur_y = 4; #1;
    step(); #1;
    check("wait rd mem_we", mem_we, 0);
    for (int k = 0; k < 4; k++) begin
      step(); disp_active = 1'b1; cell_x = 3; cell_y = 5; #1;
      check("wait disp mem_we", mem_we, 0);
      check("wait disp done", edit_done, 0);
      check("wait disp mem_x", mem_x, 3);
    end
    step(); disp_active = 1'b0; #1;
    check("wait wr mem_we", mem_we, 1);
    check("wait wr wdata", mem_wdata, 0);
    check("wait wr mem_x", mem_x, 4);
    check("wait wr done", edit_done, 1);
    step(); edit_req = 1'b0; #1;
    check("wait ram(4,4)", ram[4][4], 0);
    check("wait done low", edit_done, 0);

    // Display steals the EDIT_RD cycle; the read is retried
    step(); edit_req = 1'b1; cur_x = 6; cur_y = 6; #1;
    check("pre rd mem_x", mem_x, 6);
    step(); disp_active = 1'b1; #1;
    check("pre disp mem_x", mem_x, 3);
    check("pre disp mem_we", mem_we, 0);
    step(); disp_active = 1'b0; #1;
    check("pre retry mem_x", mem_x, 6);
    check("pre retry mem_we", mem_we, 0);
    check("pre retry done", edit_done, 0);
    step(); #1;
    check("pre cap mem_we", mem_we, 0);
    check("pre cap done", edit_done, 0);
    step(); #1;
    check("pre wr mem_we", mem_we, 1);
    check("pre wr wdata", mem_wdata, 1);
    check("pre wr done", edit_done, 1);
    step(); edit_req = 1'b0; #1;
    check("pre ram(6,6)", ram[6][6], 1);

    // Reset during EDIT_WAIT abandons the toggle
    step(); edit_req = 1'b1; cur_x = 12; cur_y = 12; #1;
    step(); #1;
    check("mid cell_state pre", cell_state, 1);
    step(); rst = 1'b1; #1;
    check("mid rst mem_we", mem_we, 0);
    check("mid rst done", edit_done, 0);
    check("mid rst mem_x", mem_x, 0);
    check("mid rst mem_y", mem_y, 0);
    check("mid rst cell_state", cell_state, 0);
    check("mid rst evo_gnt", evo_gnt, 0);
    check("mid rst evo_rvalid", evo_rvalid, 0);
    check("mid rst evo_rdata", evo_rdata, 0);
    step(); rst = 1'b0; edit_req = 1'b0; #1;
    check("mid post mem_we", mem_we, 0);
    check("mid ram(12,12)", ram[12][12], 0);

    // Both requesters held: edit, evo, edit, evo (prio_edit = 1 after reset)
    exp_done = 10'b0010000100;
    exp_gnt  = 10'b1000010000;
    exp_we   = 10'b1010010100;
    exp_wd   = 10'b1000010100;
    step(); mode = 1'b0; edit_req = 1'b1; cur_x = 8; cur_y = 8;
    evo_req = 1'b1; evo_we = 1'b1; evo_x = 10; evo_y = 10; evo_wdata = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      #1;
      check($sformatf("alt done c%0d", i), edit_done, exp_done[i]);
      check($sformatf("alt gnt c%0d", i), evo_gnt, exp_gnt[i]);
      check($sformatf("alt we c%0d", i), mem_we, exp_we[i]);
      check($sformatf("alt wdata c%0d", i), mem_wdata, exp_wd[i]);
    end
    step(); edit_req = 1'b0; evo_req = 1'b0; evo_we = 1'b0; evo_wdata = 1'b0; #1;
    check("alt ram(10,10)", ram[10][10], 1);
    check("alt ram(8,8)", ram[8][8], 0);

    // Edit mode blocks evolve; run mode grants the read
    step(); mode = 1'b1; evo_req = 1'b1; evo_we = 1'b0; evo_x = 1; evo_y = 1; #1;
    check("mode gnt c0", evo_gnt, 0);
    for (int k = 1; k < 20; k++) begin
      step(); #1;
      check($sformatf("mode gnt c%0d", k), evo_gnt, 0);
    end
    step(); mode = 1'b0; #1;
    check("run gnt", evo_gnt, 1);
    check("run mem_x", mem_x, 1);
    check("run mem_y", mem_y, 1);
    check("run mem_we", mem_we, 0);
    step(); mode = 1'b1; #1;
    check("run rvalid", evo_rvalid, 1);
    check("run rdata", evo_rdata, 1);
    check("run gnt after", evo_gnt, 0);
    step(); evo_req = 1'b0; #1;
    check("run rvalid low", evo_rvalid, 0);
    check("run rdata hold", evo_rdata, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
